jk_excitation_driver: RTL and testbench
=======================================

Name: jk_excitation_driver

Overview:
- Drives an internal bank of W JK flip-flops to a requested target word.
- Accepts a target over a valid/ready handshake and computes per-bit J/K excitation from the current Q.
- Applies the excitation for one clock, then checks Q against the target.
- Reports done, mismatch and the number of bits that flipped. It is the stimulus end of the JK flip-flop interface: it produces J/K from a desired next state instead of observing Q from J/K.

Parameters:
- W, 4, number of JK flip-flops in the bank (1..32).
- CW, $clog2(W+1), width of the flip count (derived; not overridable).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  target word is offered.
- in_ready  output  1  block can accept a target (high only in IDLE).
- in_target  input  W  requested next Q value.
- in_mode  input  1  0 = set/reset excitation, 1 = toggle excitation.
- inj_hold  input  1  fault injection: masks excitation to the bank during EXCITE.
- j_out  output  W  computed J vector; nonzero only in EXCITE.
- k_out  output  W  computed K vector; nonzero only in EXCITE.
- q  output  W  current bank state.
- busy  output  1  high in EXCITE and CHECK.
- done  output  1  one-cycle pulse in CHECK.
- mismatch  output  1  result of the last check; q != target.
- flip_count  output  CW  popcount of (j_out | k_out) for the last operation.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state goes to IDLE.
  - q=0, j_out=0, k_out=0, done=0, busy=0, mismatch=0, flip_count=0, in_ready=1.
  - Applies in any state; an operation in progress is abandoned with no done pulse.
- States are IDLE, EXCITE and CHECK. busy=(state!=IDLE). done=(state==CHECK). in_ready=(state==IDLE). All are decoded from the registered state.
- IDLE:
  - If in_valid && in_ready at edge T, latch in_target into tgt_r and in_mode into mode_r, then go to EXCITE.
  - Otherwise stay in IDLE.
- EXCITE (exactly one cycle, between edges T and T+1):
  - mode_r=0, per bit i:
    - q=0, t=0 gives j=0, k=0.
    - q=0, t=1 gives j=1, k=0.
    - q=1, t=0 gives j=0, k=1.
    - q=1, t=1 gives j=0, k=0.
  - mode_r=1: j[i]=k[i]=q[i]^t[i], so changing bits toggle.
  - The bank receives j_out/k_out, or zeros if inj_hold=1. j_out/k_out always show the computed values.
  - At edge T+1:
    - The bank updates with JK semantics: 00 hold, 10 set, 01 reset, 11 toggle.
    - cnt_r <= popcount(j_out|k_out).
    - state goes to CHECK.
- CHECK (one cycle, between edges T+1 and T+2):
  - done=1.
  - At edge T+2: mismatch <= (q != tgt_r), flip_count <= cnt_r, state goes to IDLE.
  - mismatch and flip_count hold until the next CHECK completes.
- Outside EXCITE, j_out=k_out=0 and the bank holds.
- Latency and throughput: accept at T, q valid at T+1, done high during the T+1..T+2 cycle, results valid from T+2. Throughput is 1 operation per 3 cycles. in_valid outside IDLE is ignored and not queued.
- Boundaries:
  - Target equal to q gives j=k=0, flip_count=0, mismatch=0.
  - Target all-ones from q=0 gives flip_count=W (CW holds W without overflow).
  - inj_hold with target != q gives mismatch=1 and q unchanged; flip_count still reports the computed excitation.
  - in_target/in_mode changing after acceptance has no effect.
  - Both modes must yield identical q.

Decomposition:
- Package jk_pkg:
  - mode constants MODE_SR=0 and MODE_TOGGLE=1.
  - state encoding IDLE=2'd0, EXCITE=2'd1, CHECK=2'd2. 2'd3 is unreachable and recovers to IDLE.
  - per-bit excitation function jk_excite(q, t, mode) returning {j,k}.
- Sub-module jk_reg_bank:
  - W-wide parameterised JK register with clk and rst (synchronous, active-high, clears to 0).
  - Inputs j and k, output q.
  - Instantiated once.

Test Plan:
- Reset then q=0, in_valid=1, target=4'b1010, mode=0 at T: in_ready=0 at T+1, j_out=1010, k_out=0000 in EXCITE, q=1010 at T+1, done pulse 1 cycle, mismatch=0, flip_count=2 at T+2.
- From q=1010, target=4'b0110, mode=1: j_out=k_out=1100, q=0110, flip_count=2, mismatch=0. Repeat with mode=0: j_out=0100, k_out=1000, same q.
- From q=0110, target=4'b0110, either mode: j_out=k_out=0, q unchanged, flip_count=0, done still pulses.
- inj_hold=1 in EXCITE, q=0000, target=1111: q stays 0000, mismatch=1, flip_count=4. Next clean op to 1111 clears mismatch to 0.
- Hold in_valid=1 continuously with targets 0001, 0011, 0111: accepts exactly every 3rd cycle, no target dropped or duplicated, final q=0111.
- Assert rst during CHECK: no further done, q=0, mismatch=0, flip_count=0, in_ready=1 the cycle after the reset edge.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and excitation rule for the JK excitation driver.
// Maps a desired next state onto per-bit J/K inputs.
package jk_pkg;

  localparam logic MODE_SR     = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXCITE = 2'd1,
    CHECK  = 2'd2
  } state_t;

  // Returns {j,k} that moves q to t on the next edge.
  function automatic logic [1:0] jk_excite(
    input logic q,
    input logic t,
    input logic mode
  );
    if (mode == MODE_TOGGLE) begin
      return {q ^ t, q ^ t};
    end
    return {~q & t, q & ~t};
  endfunction

endpackage

// File: rtl/jk_reg_bank.sv
// W-wide bank of JK flip-flops.
// Synchronous active-high reset clears every bit.
module jk_reg_bank #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] j,
  input  logic [W-1:0] k,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= (j & ~q) | (~k & q);
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a JK bank to a requested word, then checks the result.
// One operation per three cycles: IDLE -> EXCITE -> CHECK.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter  int W  = 4,
  localparam int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_target,
  input  logic          in_mode,
  input  logic          inj_hold,
  output logic [W-1:0]  j_out,
  output logic [W-1:0]  k_out,
  output logic [W-1:0]  q,
  output logic          busy,
  output logic          done,
  output logic          mismatch,
  output logic [CW-1:0] flip_count
);

  state_t        state_q;
  state_t        state_d;
  logic [W-1:0]  tgt_r;
  logic          mode_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] pc;
  logic [W-1:0]  j_calc;
  logic [W-1:0]  k_calc;
  logic [W-1:0]  bank_j;
  logic [W-1:0]  bank_k;
  logic          excite;

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == CHECK);
  assign excite   = (state_q == EXCITE);

  always_comb begin
    j_calc = '0;
    k_calc = '0;
    for (int i = 0; i < W; i++) begin
      {j_calc[i], k_calc[i]} = jk_excite(q[i], tgt_r[i], mode_r);
    end
  end

  assign j_out  = excite ? j_calc : '0;
  assign k_out  = excite ? k_calc : '0;
  // Fault injection starves the bank but leaves the visible excitation intact.
  assign bank_j = inj_hold ? '0 : j_out;
  assign bank_k = inj_hold ? '0 : k_out;

  always_comb begin
    pc = '0;
    for (int i = 0; i < W; i++) begin
      pc = pc + CW'(j_out[i] | k_out[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = EXCITE;
      EXCITE:  state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tgt_r      <= '0;
      mode_r     <= MODE_SR;
      cnt_r      <= '0;
      mismatch   <= 1'b0;
      flip_count <= '0;
    end else begin
      state_q <= state_d;
      if (in_ready && in_valid) begin
        tgt_r  <= in_target;
        mode_r <= in_mode;
      end
      if (excite) begin
        cnt_r <= pc;
      end
      if (done) begin
        mismatch   <= (q != tgt_r);
        flip_count <= cnt_r;
      end
    end
  end

  jk_reg_bank #(
    .W(W)
  ) u_bank (
    .clk(clk),
    .rst(rst),
    .j  (bank_j),
    .k  (bank_k),
    .q  (q)
  );

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Scoreboard bench for jk_excitation_driver.
// Stimulus pushes expected results; a monitor checks on EXCITE/done.
module tb_jk_excitation_driver;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_target;
  logic          in_mode;
  logic          inj_hold;
  logic [W-1:0]  j_out;
  logic [W-1:0]  k_out;
  logic [W-1:0]  q;
  logic          busy;
  logic          done;
  logic          mismatch;
  logic [CW-1:0] flip_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] q;
    int           flips;
    logic         mm;
  } exp_t;

  exp_t sb[$];
  logic [W-1:0] mq;

  always #5 clk = ~clk;

  jk_excitation_driver #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_target (in_target),
    .in_mode   (in_mode),
    .inj_hold  (inj_hold),
    .j_out     (j_out),
    .k_out     (k_out),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .mismatch  (mismatch),
    .flip_count(flip_count)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: the bank ends at the target unless held; J|K covers q^t.
  task automatic push(input logic [W-1:0] t, input logic m, input logic h);
    exp_t e;
    if (m) begin
      e.j = mq ^ t;
      e.k = mq ^ t;
    end else begin
      e.j = t & ~mq;
      e.k = mq & ~t;
    end
    e.q     = h ? mq : t;
    e.flips = $countones(mq ^ t);
    e.mm    = (e.q != t);
    mq      = e.q;
    sb.push_back(e);
  endtask

  task automatic do_op(input logic [W-1:0] t, input logic m, input logic h);
    int n;
    n = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_target = t;
    in_mode   = m;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    push(t, m, h);
    @(negedge clk);
    in_valid  = 1'b0;
    in_target = W'($urandom);
    in_mode   = 1'($urandom);
    inj_hold  = h;
    chk("ready_low_in_excite", int'(in_ready), 0);
    @(negedge clk);
    inj_hold = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && busy && !done) begin
        if (sb.size() == 0) begin
          chk("excite_unexpected", 1, 0);
        end else begin
          chk("j_out", int'(j_out), int'(sb[0].j));
          chk("k_out", int'(k_out), int'(sb[0].k));
        end
      end
      if (!rst && done) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("q_after_excite", int'(q), int'(e.q));
          @(posedge clk);
          #1;
          if (!rst) begin
            chk("mismatch", int'(mismatch), int'(e.mm));
            chk("flip_count", int'(flip_count), e.flips);
            chk("done_one_cycle", int'(done), 0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [W-1:0] seq [3];
    logic [W-1:0] t;
    int idx;
    int n;
    int ndone;
    time last;
    seq[0] = 4'b0001;
    seq[1] = 4'b0011;
    seq[2] = 4'b0111;
    mq = '0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_target = '0;
    in_mode = 1'b0;
    inj_hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_q", int'(q), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_jk", int'(j_out | k_out), 0);
    chk("rst_mismatch", int'(mismatch), 0);
    chk("rst_flip", int'(flip_count), 0);

    do_op(4'b1010, 1'b0, 1'b0);
    do_op(4'b0110, 1'b1, 1'b0);
    do_op(4'b1010, 1'b0, 1'b0);
    do_op(4'b0110, 1'b0, 1'b0);
    do_op(4'b0110, 1'b0, 1'b0);
    do_op(4'b0110, 1'b1, 1'b0);
    do_op(4'b0000, 1'b0, 1'b0);
    do_op(4'b1111, 1'b0, 1'b1);
    do_op(4'b1111, 1'b1, 1'b0);
    drain();
    chk("q_ones", int'(q), 15);

    // Back-to-back requests with in_valid never dropped.
    @(negedge clk);
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_target = seq[0];
    idx  = 0;
    n    = 0;
    last = 0;
    while (idx < 3 && n < 40) begin
      if (in_ready) begin
        @(posedge clk);
        push(seq[idx], 1'b0, 1'b0);
        if (idx > 0) chk("accept_spacing", int'(($time - last) / 10), 3);
        last = $time;
        idx++;
        @(negedge clk);
        if (idx < 3) in_target = seq[idx];
      end else begin
        @(negedge clk);
      end
      n++;
    end
    in_valid = 1'b0;
    chk("stream_accepts", idx, 3);
    drain();
    chk("stream_final_q", int'(q), 7);

    for (int i = 0; i < 40; i++) begin
      t = W'($urandom);
      do_op(t, 1'($urandom), ($urandom_range(0, 3) == 0));
    end
    drain();

    // Reset while the check cycle is in flight.
    do_op(W'($urandom), 1'b0, 1'b0);
    chk("in_check", int'(done), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mq = '0;
    chk("rstchk_q", int'(q), 0);
    chk("rstchk_mismatch", int'(mismatch), 0);
    chk("rstchk_flip", int'(flip_count), 0);
    chk("rstchk_ready", int'(in_ready), 1);
    chk("rstchk_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      ndone += int'(done);
    end
    chk("no_done_after_rst", ndone, 0);
    chk("sb_empty_end", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
